writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register and write-back stage of the MIPS datapath; sits directly upstream of the register file and drives its RD, write-data and write-enable inputs.
- Captures MEM-stage results on posedge CLK, aligns and extends load data, and selects the write-back source.
- Protects $zero, flags misaligned loads, and counts retired instructions.
- The register file writes on negedge CLK, so all outputs are registered and stable before that edge.

Parameters:
- DATA_W, 32, datapath width (only 32 is supported).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- I_MEMWB_VALID  input  1  MEM stage presents a real instruction.
- I_MEMWB_ALU_RESULT  input  32  ALU result; for loads, the byte address.
- I_MEMWB_MEM_DATA  input  32  raw aligned word from data memory.
- I_MEMWB_PC_PLUS4  input  32  link value for JAL/JALR.
- I_MEMWB_RD  input  5  destination register.
- I_MEMWB_REGWR  input  1  instruction writes a register.
- I_MEMWB_WB_SEL  input  2  write-back source: 00 ALU, 01 load, 10 link, 11 reserved (treated as ALU).
- I_MEMWB_LOAD_SIZE  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- I_MEMWB_LOAD_UNSIGNED  input  1  zero-extend instead of sign-extend.
- I_STALL  input  1  MEM stage not ready; insert a bubble.
- I_FLUSH  input  1  kill the incoming instruction.
- O_WB_RD  output  5  to register file RD.
- O_WB_WRITE_DATA  output  32  to register file write data.
- O_WB_REGWR  output  1  to register file write enable.
- O_WB_VALID  output  1  instruction retiring this cycle.
- O_WB_MISALIGNED  output  1  sticky misaligned-load flag.
- O_WB_RETIRED  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (RESET=0, asynchronous): all outputs go to 0, including the counter and the sticky flag. Release is synchronous to the next posedge.
- Latency: one cycle. Inputs present at posedge N appear on the outputs after posedge N. The register file consumes them at the following negedge.
- Load alignment is little-endian, with offset = ALU_RESULT[1:0].
  - Byte: selects MEM_DATA[8*off+7 : 8*off].
  - Half: offset 0 selects [15:0]; offset 2 selects [31:16].
  - Word: the full word.
  - Extension is sign or zero per LOAD_UNSIGNED, to 32 bits.
- Misaligned load: WB_SEL=01 with half and ALU_RESULT[0]=1, or word and ALU_RESULT[1:0]≠0.
  - O_WB_REGWR=0 for that instruction.
  - O_WB_MISALIGNED sets and holds until reset.
  - The instruction still counts as retired (O_WB_VALID=1).
- Write-data mux is computed before the pipeline register: ALU_RESULT, the aligned load value, or PC_PLUS4.
- O_WB_REGWR = VALID & REGWR & (RD≠0) & ~misaligned, all registered. A write to $zero is never issued, but O_WB_RD and O_WB_WRITE_DATA still carry the values.
- I_FLUSH (priority over I_STALL): next state is a bubble. VALID=0, REGWR=0, RD=0, WRITE_DATA=0.
- I_STALL (no flush): next state is a bubble. VALID=0 and REGWR=0; RD and WRITE_DATA hold their previous values.
- I_MEMWB_VALID=0 behaves as a bubble with data fields captured as presented.
- Counter: increments by 1 on each posedge where the newly captured VALID=1, i.e. it is registered alongside O_WB_VALID and matches it cycle-for-cycle. It wraps from 2^CNT_W−1 to 0 with no flag.
- Simultaneous misaligned load and flush: flush wins; the sticky flag is not set.
- Reset mid-operation clears everything immediately. The instruction in flight is lost and is not counted.

Test Plan:
- Reset, then LW with ALU_RESULT=0x100, MEM_DATA=0xDEADBEEF, RD=5, WB_SEL=01 → next cycle: REGWR=1, RD=5, WRITE_DATA=0xDEADBEEF, RETIRED=1.
- LB at offset 3 with MEM_DATA=0x80112233 gives WRITE_DATA=0xFFFFFF80. LBU at the same address gives 0x00000080. LH at offset 2 gives 0xFFFF8011. LHU at offset 0 gives 0x00002233.
- JAL-style with WB_SEL=10, PC_PLUS4=0x0040_0008, RD=31 → WRITE_DATA=0x00400008, REGWR=1. ADD to RD=0 → REGWR=0, VALID=1, counter increments.
- LW at address 0x102 → REGWR=0, O_WB_MISALIGNED=1 and still 1 ten cycles later; a later aligned LW writes normally.
- Back-to-back valid ALU ops with I_STALL=1 on cycle 2 and I_FLUSH=1 on cycle 3 (I_STALL also 1) → those cycles give VALID=0 and REGWR=0; the stall cycle holds WRITE_DATA, the flush cycle gives WRITE_DATA=0; RETIRED is 2 after four inputs.
- Counter preset by forcing it to 0xFFFFFFFF, then one valid instruction → RETIRED=0. Assert RESET low between posedges mid-stream → outputs are 0 immediately, with no write issued at the following negedge.

Source files
------------

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register and write-back stage
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_MEMWB_VALID,
    input  logic [DATA_W-1:0] I_MEMWB_ALU_RESULT,
    input  logic [DATA_W-1:0] I_MEMWB_MEM_DATA,
    input  logic [DATA_W-1:0] I_MEMWB_PC_PLUS4,
    input  logic [4:0]        I_MEMWB_RD,
    input  logic              I_MEMWB_REGWR,
    input  logic [1:0]        I_MEMWB_WB_SEL,
    input  logic [1:0]        I_MEMWB_LOAD_SIZE,
    input  logic              I_MEMWB_LOAD_UNSIGNED,
    input  logic              I_STALL,
    input  logic              I_FLUSH,
    output logic [4:0]        O_WB_RD,
    output logic [DATA_W-1:0] O_WB_WRITE_DATA,
    output logic              O_WB_REGWR,
    output logic              O_WB_VALID,
    output logic              O_WB_MISALIGNED,
    output logic [CNT_W-1:0]  O_WB_RETIRED
);

    logic [1:0]        offset;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] wb_data;
    logic              misaligned;
    logic              is_load;
    logic              sign_fill;

    assign offset  = I_MEMWB_ALU_RESULT[1:0];
    assign is_load = (I_MEMWB_WB_SEL == 2'b01);

    always_comb begin
        byte_sel = I_MEMWB_MEM_DATA[7:0];
        case (offset)
            2'd0: byte_sel = I_MEMWB_MEM_DATA[7:0];
            2'd1: byte_sel = I_MEMWB_MEM_DATA[15:8];
            2'd2: byte_sel = I_MEMWB_MEM_DATA[23:16];
            2'd3: byte_sel = I_MEMWB_MEM_DATA[31:24];
            default: byte_sel = I_MEMWB_MEM_DATA[7:0];
        endcase
    end

    // Halfword lane follows address bit 1; odd offsets are flagged misaligned anyway.
    assign half_sel = offset[1] ? I_MEMWB_MEM_DATA[31:16] : I_MEMWB_MEM_DATA[15:0];

    always_comb begin
        sign_fill = 1'b0;
        load_val  = I_MEMWB_MEM_DATA;
        case (I_MEMWB_LOAD_SIZE)
            2'b00: begin
                sign_fill = ~I_MEMWB_LOAD_UNSIGNED & byte_sel[7];
                load_val  = {{(DATA_W-8){sign_fill}}, byte_sel};
            end
            2'b01: begin
                sign_fill = ~I_MEMWB_LOAD_UNSIGNED & half_sel[15];
                load_val  = {{(DATA_W-16){sign_fill}}, half_sel};
            end
            default: load_val = I_MEMWB_MEM_DATA;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        if (is_load) begin
            if (I_MEMWB_LOAD_SIZE == 2'b01)
                misaligned = offset[0];
            else if (I_MEMWB_LOAD_SIZE[1])
                misaligned = (offset != 2'b00);
        end
    end

    always_comb begin
        wb_data = I_MEMWB_ALU_RESULT;
        case (I_MEMWB_WB_SEL)
            2'b01:   wb_data = load_val;
            2'b10:   wb_data = I_MEMWB_PC_PLUS4;
            default: wb_data = I_MEMWB_ALU_RESULT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            O_WB_RD         <= '0;
            O_WB_WRITE_DATA <= '0;
            O_WB_REGWR      <= 1'b0;
            O_WB_VALID      <= 1'b0;
            O_WB_MISALIGNED <= 1'b0;
            O_WB_RETIRED    <= '0;
        end else if (I_FLUSH) begin
            O_WB_RD         <= '0;
            O_WB_WRITE_DATA <= '0;
            O_WB_REGWR      <= 1'b0;
            O_WB_VALID      <= 1'b0;
        end else if (I_STALL) begin
            O_WB_REGWR      <= 1'b0;
            O_WB_VALID      <= 1'b0;
        end else begin
            O_WB_RD         <= I_MEMWB_RD;
            O_WB_WRITE_DATA <= wb_data;
            O_WB_VALID      <= I_MEMWB_VALID;
            O_WB_REGWR      <= I_MEMWB_VALID & I_MEMWB_REGWR &
                               (I_MEMWB_RD != 5'd0) & ~misaligned;
            if (I_MEMWB_VALID && misaligned)
                O_WB_MISALIGNED <= 1'b1;
            if (I_MEMWB_VALID)
                O_WB_RETIRED <= O_WB_RETIRED + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] alu = '0;
    logic [31:0] mem = '0;
    logic [31:0] pc = '0;
    logic [4:0]  rd = '0;
    logic        regwr = 1'b0;
    logic [1:0]  sel = '0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic [4:0]  o_rd;
    logic [31:0] o_wd;
    logic        o_we, o_valid, o_mis;
    logic [31:0] o_ret;

    logic [4:0]  w_rd;
    logic [31:0] w_wd;
    logic        w_we, w_valid, w_mis;
    logic [2:0]  w_ret;

    always #5 CLK = ~CLK;

    writeback_stage dut (
        .CLK(CLK), .RESET(RESET), .I_MEMWB_VALID(valid), .I_MEMWB_ALU_RESULT(alu),
        .I_MEMWB_MEM_DATA(mem), .I_MEMWB_PC_PLUS4(pc), .I_MEMWB_RD(rd),
        .I_MEMWB_REGWR(regwr), .I_MEMWB_WB_SEL(sel), .I_MEMWB_LOAD_SIZE(size),
        .I_MEMWB_LOAD_UNSIGNED(uns), .I_STALL(stall), .I_FLUSH(flush),
        .O_WB_RD(o_rd), .O_WB_WRITE_DATA(o_wd), .O_WB_REGWR(o_we),
        .O_WB_VALID(o_valid), .O_WB_MISALIGNED(o_mis), .O_WB_RETIRED(o_ret)
    );

    writeback_stage #(.CNT_W(3)) dut_w (
        .CLK(CLK), .RESET(RESET), .I_MEMWB_VALID(valid), .I_MEMWB_ALU_RESULT(alu),
        .I_MEMWB_MEM_DATA(mem), .I_MEMWB_PC_PLUS4(pc), .I_MEMWB_RD(rd),
        .I_MEMWB_REGWR(regwr), .I_MEMWB_WB_SEL(sel), .I_MEMWB_LOAD_SIZE(size),
        .I_MEMWB_LOAD_UNSIGNED(uns), .I_STALL(stall), .I_FLUSH(flush),
        .O_WB_RD(w_rd), .O_WB_WRITE_DATA(w_wd), .O_WB_REGWR(w_we),
        .O_WB_VALID(w_valid), .O_WB_MISALIGNED(w_mis), .O_WB_RETIRED(w_ret)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] alu, mem, pc;
        logic [4:0]  rd;
        logic        regwr;
        logic [1:0]  sel, size;
        logic        uns;
        logic [31:0] exp_wd;
        logic        exp_we;
    } vec_t;

    vec_t vecs[11];

    // Reference model state: what the outputs should show after the next edge
    logic [4:0]  m_rd;
    logic [31:0] m_wd, m_cnt;
    logic        m_we, m_valid, m_mis, m_cur_mis;

    task automatic model_reset();
        m_rd = 0; m_wd = 0; m_cnt = 0; m_we = 0; m_valid = 0; m_mis = 0; m_cur_mis = 0;
    endtask

    task automatic model_step();
        longint unsigned word, v;
        int off;
        logic bad;
        m_cur_mis = 0;
        if (flush) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_wd = 0;
        end else if (stall) begin
            m_valid = 0; m_we = 0;
        end else begin
            off = int'(alu % 4);
            word = longint'(mem);
            if (size == 2'b00) begin
                v = (word >> (8 * off)) % 256;
                if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
            end else if (size == 2'b01) begin
                v = (word >> (16 * (off / 2))) % 65536;
                if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
            end else begin
                v = word;
            end
            bad = (sel == 2'b01) && ((size == 2'b01 && off % 2 == 1) ||
                                     (size >= 2'b10 && off != 0));
            m_cur_mis = bad;
            m_wd = (sel == 2'b10) ? pc : (sel == 2'b01) ? v[31:0] : alu;
            m_rd = rd;
            m_valid = valid;
            m_we = valid && regwr && (rd != 0) && !bad;
            if (valid && bad) m_mis = 1;
            if (valid) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic idle_inputs();
        valid = 0; alu = 0; mem = 0; pc = 0; rd = 0; regwr = 0;
        sel = 0; size = 0; uns = 0; stall = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 0;
        @(posedge CLK); #1;
        RESET = 1;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                            input logic [4:0] r, input logic [1:0] s, input logic [1:0] z,
                            input logic u);
        valid = 1; alu = a; mem = m; pc = p; rd = r; regwr = 1; sel = s; size = z; uns = u;
    endtask

    initial begin
        vecs[0]  = '{32'h100, 32'hDEADBEEF, 32'h0, 5'd5, 1'b1, 2'b01, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1};
        vecs[1]  = '{32'h103, 32'h80112233, 32'h0, 5'd6, 1'b1, 2'b01, 2'b00, 1'b0, 32'hFFFFFF80, 1'b1};
        vecs[2]  = '{32'h103, 32'h80112233, 32'h0, 5'd6, 1'b1, 2'b01, 2'b00, 1'b1, 32'h00000080, 1'b1};
        vecs[3]  = '{32'h102, 32'h80112233, 32'h0, 5'd7, 1'b1, 2'b01, 2'b01, 1'b0, 32'hFFFF8011, 1'b1};
        vecs[4]  = '{32'h100, 32'h80112233, 32'h0, 5'd7, 1'b1, 2'b01, 2'b01, 1'b1, 32'h00002233, 1'b1};
        vecs[5]  = '{32'h101, 32'h80112233, 32'h0, 5'd8, 1'b1, 2'b01, 2'b00, 1'b0, 32'h00000022, 1'b1};
        vecs[6]  = '{32'h1234, 32'h0, 32'h00400008, 5'd31, 1'b1, 2'b10, 2'b00, 1'b0, 32'h00400008, 1'b1};
        vecs[7]  = '{32'h55, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h00000055, 1'b0};
        vecs[8]  = '{32'hCAFEF00D, 32'h1, 32'h2, 5'd9, 1'b1, 2'b11, 2'b00, 1'b0, 32'hCAFEF00D, 1'b1};
        vecs[9]  = '{32'h100, 32'hDEADBEEF, 32'h0, 5'd10, 1'b1, 2'b01, 2'b11, 1'b0, 32'hDEADBEEF, 1'b1};
        vecs[10] = '{32'h1, 32'h0, 32'h0, 5'd3, 1'b0, 2'b00, 2'b00, 1'b0, 32'h00000001, 1'b0};

        // Reset state
        idle_inputs();
        #2;
        chk("reset_wd", o_wd, 0);
        chk("reset_we", {31'b0, o_we}, 0);
        chk("reset_valid", {31'b0, o_valid}, 0);
        chk("reset_ret", o_ret, 0);
        chk("reset_mis", {31'b0, o_mis}, 0);
        do_reset();

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            valid = 1; alu = vecs[i].alu; mem = vecs[i].mem; pc = vecs[i].pc; rd = vecs[i].rd;
            regwr = vecs[i].regwr; sel = vecs[i].sel; size = vecs[i].size; uns = vecs[i].uns;
            tick();
            chk($sformatf("vec%0d_wd", i), o_wd, vecs[i].exp_wd);
            chk($sformatf("vec%0d_we", i), {31'b0, o_we}, {31'b0, vecs[i].exp_we});
            chk($sformatf("vec%0d_rd", i), {27'b0, o_rd}, {27'b0, vecs[i].rd});
            chk($sformatf("vec%0d_valid", i), {31'b0, o_valid}, 1);
            chk($sformatf("vec%0d_ret", i), o_ret, i + 1);
            chk($sformatf("vec%0d_mis", i), {31'b0, o_mis}, 0);
        end

        // Flush beats a simultaneous misaligned load
        do_reset();
        drive_op(32'h102, 32'h11111111, 0, 5'd4, 2'b01, 2'b10, 0);
        flush = 1;
        tick();
        chk("flushmis_mis", {31'b0, o_mis}, 0);
        chk("flushmis_valid", {31'b0, o_valid}, 0);
        chk("flushmis_ret", o_ret, 0);

        // Misaligned word load is sticky; later aligned load still writes
        do_reset();
        drive_op(32'h102, 32'h11111111, 0, 5'd4, 2'b01, 2'b10, 0);
        tick();
        chk("mis_we", {31'b0, o_we}, 0);
        chk("mis_valid", {31'b0, o_valid}, 1);
        chk("mis_flag", {31'b0, o_mis}, 1);
        chk("mis_ret", o_ret, 1);
        idle_inputs();
        repeat (10) tick();
        chk("mis_sticky", {31'b0, o_mis}, 1);
        drive_op(32'h104, 32'h12345678, 0, 5'd8, 2'b01, 2'b10, 0);
        tick();
        chk("mis_after_we", {31'b0, o_we}, 1);
        chk("mis_after_wd", o_wd, 32'h12345678);

        // Stall then flush in a run of ALU ops
        do_reset();
        drive_op(32'hA1, 0, 0, 5'd1, 2'b00, 2'b00, 0);
        tick();
        chk("sf1_wd", o_wd, 32'hA1);
        drive_op(32'hB2, 0, 0, 5'd2, 2'b00, 2'b00, 0); stall = 1;
        tick();
        chk("sf2_valid", {31'b0, o_valid}, 0);
        chk("sf2_we", {31'b0, o_we}, 0);
        chk("sf2_wd_hold", o_wd, 32'hA1);
        chk("sf2_rd_hold", {27'b0, o_rd}, 1);
        drive_op(32'hC3, 0, 0, 5'd3, 2'b00, 2'b00, 0); stall = 1; flush = 1;
        tick();
        chk("sf3_valid", {31'b0, o_valid}, 0);
        chk("sf3_wd", o_wd, 0);
        chk("sf3_rd", {27'b0, o_rd}, 0);
        drive_op(32'hD4, 0, 0, 5'd4, 2'b00, 2'b00, 0); stall = 0; flush = 0;
        tick();
        chk("sf4_wd", o_wd, 32'hD4);
        chk("sf4_ret", o_ret, 2);

        // Counter wrap on a narrow counter instance
        do_reset();
        drive_op(32'h10, 0, 0, 5'd2, 2'b00, 2'b00, 0);
        repeat (7) tick();
        chk("wrap_7", {29'b0, w_ret}, 7);
        tick();
        chk("wrap_0", {29'b0, w_ret}, 0);
        chk("wrap_wide", o_ret, 8);

        // Asynchronous reset between edges
        drive_op(32'h77, 0, 0, 5'd9, 2'b00, 2'b00, 0);
        tick();
        chk("arst_pre_we", {31'b0, o_we}, 1);
        #1 RESET = 0;
        #1;
        chk("arst_we", {31'b0, o_we}, 0);
        chk("arst_wd", o_wd, 0);
        chk("arst_ret", o_ret, 0);
        @(negedge CLK);
        chk("arst_neg_we", {31'b0, o_we}, 0);
        tick();
        chk("arst_held_ret", o_ret, 0);
        RESET = 1;

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            valid = ($urandom_range(0, 9) != 0);
            alu = $urandom; mem = $urandom; pc = $urandom;
            rd = 5'($urandom_range(0, 31)); regwr = 1'($urandom);
            sel = 2'($urandom); size = 2'($urandom); uns = 1'($urandom);
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 14) == 0);
            model_step();
            tick();
            if (!m_cur_mis) chk($sformatf("rnd%0d_wd", i), o_wd, m_wd);
            chk($sformatf("rnd%0d_rd", i), {27'b0, o_rd}, {27'b0, m_rd});
            chk($sformatf("rnd%0d_we", i), {31'b0, o_we}, {31'b0, m_we});
            chk($sformatf("rnd%0d_valid", i), {31'b0, o_valid}, {31'b0, m_valid});
            chk($sformatf("rnd%0d_mis", i), {31'b0, o_mis}, {31'b0, m_mis});
            chk($sformatf("rnd%0d_ret", i), o_ret, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
